// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: func codes, active-low glyphs and converter state for the calculator display.
package calc_disp_pkg;
  localparam logic [2:0] FUNC_NONE = 3'd0;
  localparam logic [2:0] FUNC_ADD  = 3'd1;
  localparam logic [2:0] FUNC_SUB  = 3'd2;
  localparam logic [2:0] FUNC_MUL  = 3'd3;
  localparam logic [2:0] FUNC_DIV  = 3'd4;
  localparam logic [2:0] FUNC_ERR  = 3'd5;
  localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30, SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12, SEG_6 = 7'h02, SEG_7 = 7'h78, SEG_8 = 7'h00, SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08, SEG_E = 7'h06, SEG_R = 7'h2F, SEG_N = 7'h2B, SEG_D = 7'h21;
  localparam logic [6:0] SEG_DASH = 7'h3F, SEG_BLANK = 7'h7F;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: digit_glyph = SEG_0;
      4'd1: digit_glyph = SEG_1;
      4'd2: digit_glyph = SEG_2;
      4'd3: digit_glyph = SEG_3;
      4'd4: digit_glyph = SEG_4;
      4'd5: digit_glyph = SEG_5;
      4'd6: digit_glyph = SEG_6;
      4'd7: digit_glyph = SEG_7;
      4'd8: digit_glyph = SEG_8;
      4'd9: digit_glyph = SEG_9;
      default: digit_glyph = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: sequential double-dabble converter, one bit per cycle, re-runs whenever value changes.
import calc_disp_pkg::*;
module calc_bin2bcd (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] value,
  output logic        busy,
  output logic        valid,
  output logic        ovf,
  output logic [15:0] bcd
);
  conv_state_t state, state_next;
  logic [13:0] shift, last;
  logic [15:0] acc, adj;
  logic [3:0]  count;
  logic        capture;
  assign capture = state == IDLE && (!valid || value != last);
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = acc[4*i +: 4] > 4'd4 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_comb begin
    state_next = state == COMMIT ? IDLE :
                 state == CONV   ? (count == 4'd0 ? COMMIT : CONV) :
                 capture         ? CONV : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // busy also covers the commit edge so the new digits are in place before it drops
  always_ff @(posedge clock) begin
    if (reset) begin
      {busy, valid, ovf} <= 3'b000;
      {last, shift, count} <= '0;
      {acc, bcd} <= '0;
    end else begin
      busy <= capture || state != IDLE;
      if (capture) begin
        shift <= value;
        last  <= value;
        acc   <= '0;
        count <= 4'd13;
      end else if (state == CONV) begin
        {acc, shift} <= {adj, shift} << 1;
        count <= count - 4'd1;
      end else if (state == COMMIT) begin
        bcd   <= acc;
        ovf   <= last > MAX_DISPLAY;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver: 4-digit multiplexed common-anode 7-segment driver for calculator results.
import calc_disp_pkg::*;
module calc_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic [2:0]  func,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [2:0]    func_r;
  logic [15:0]   bcd;
  logic          valid, ovf, lead_zero, is_op;
  logic [6:0]    numeric, op_glyph, glyph;
  calc_bin2bcd u_conv (
    .clock (clock),
    .reset (reset),
    .value (value),
    .busy  (busy),
    .valid (valid),
    .ovf   (ovf),
    .bcd   (bcd)
  );
  assign dp = 1'b1;
  // a digit is blank when it and every digit above it are zero
  assign lead_zero = sel != 2'd0 && (bcd >> {sel, 2'b00}) == 16'd0;
  assign numeric   = !valid ? SEG_BLANK : ovf ? SEG_DASH : lead_zero ? SEG_BLANK : digit_glyph(bcd[{sel, 2'b00} +: 4]);
  assign is_op     = func_r >= FUNC_ADD && func_r <= FUNC_DIV;
  assign op_glyph  = func_r == FUNC_ADD ? SEG_A : func_r == FUNC_SUB ? SEG_DASH : func_r == FUNC_MUL ? SEG_N : SEG_D;
  assign glyph     = func_r == FUNC_ERR ? (sel == 2'd0 ? SEG_BLANK : sel == 2'd3 ? SEG_E : SEG_R) :
                     is_op ? (sel == 2'd3 ? op_glyph : SEG_BLANK) : numeric;
  always_ff @(posedge clock) begin
    if (reset) begin
      func_r <= FUNC_NONE;
      cnt    <= '0;
      sel    <= 2'd0;
      seg    <= SEG_BLANK;
      an     <= 4'hF;
    end else begin
      func_r <= func;
      cnt    <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX) sel <= sel + 2'd1;
      seg    <= glyph;
      an     <= ~(4'b0001 << sel);
    end
  end
endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: random and directed stimulus checked against a cycle-level behavioural model.
module tb_calc_display_driver;
  localparam int DIV = 4;
  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clock = 0, reset = 1;
  logic [13:0] value = 0;
  logic [2:0] func = 0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp, busy;
  int checks = 0, errors = 0;
  calc_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .value(value), .func(func),
    .seg(seg), .an(an), .dp(dp), .busy(busy)
  );
  always #5 clock = ~clock;

  int m_cyc, m_disp, m_last, m_timer, m_func;
  bit m_valid, run_cmp = 0;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic e_busy;

  function automatic logic [6:0] model_glyph(int s, int f, int n);
    int p = 1;
    for (int i = 0; i < s; i++) p = p * 10;
    if (f == 5) return s == 0 ? 7'h7F : s == 3 ? 7'h06 : 7'h2F;
    if (f >= 1 && f <= 4) return s != 3 ? 7'h7F : f == 1 ? 7'h08 : f == 2 ? 7'h3F : f == 3 ? 7'h2B : 7'h21;
    if (n < 0) return 7'h7F;
    if (n > 9999) return 7'h3F;
    if (s > 0 && n < p) return 7'h7F;
    return DIG[(n / p) % 10];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_cyc = 0; m_disp = -1; m_last = 0; m_timer = 0; m_func = 0; m_valid = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_busy = 0;
    end else begin
      bit cap;
      int s;
      s = (m_cyc / DIV) % 4;
      e_seg = model_glyph(s, m_func, m_disp);
      e_an = ~(4'b0001 << s);
      m_func = int'(func);
      cap = m_timer == 0 && (!m_valid || int'(value) != m_last);
      e_busy = cap || m_timer > 0;
      if (cap) begin
        m_last = int'(value);
        m_timer = 15;
      end else if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_disp = m_last;
          m_valid = 1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clock) if (run_cmp) begin
    checks++;
    if (seg !== e_seg || an !== e_an || dp !== 1'b1 || busy !== e_busy) begin
      errors++;
      $display("FAIL model t=%0t seg=%h/%h an=%h/%h dp=%b/1 busy=%b/%b", $time, seg, e_seg, an, e_an, dp, busy, e_busy);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [6:0] shown [4];
  task automatic collect();
    for (int i = 0; i < 4; i++) shown[i] = 7'h55;
    repeat (16) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) shown[i] = seg;
    end
  endtask

  task automatic chk_digits(input string name, input logic [6:0] d3, d2, d1, d0);
    collect();
    chk({name, "_d3"}, shown[3], d3);
    chk({name, "_d2"}, shown[2], d2);
    chk({name, "_d1"}, shown[1], d1);
    chk({name, "_d0"}, shown[0], d0);
  endtask

  initial begin
    int nb;
    bit seen56;
    @(posedge clock);
    run_cmp = 1;
    repeat (2) @(negedge clock);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    reset = 0;
    @(negedge clock);
    chk("first_an", an, 4'hE);
    repeat (16) @(negedge clock);
    chk("zero_an", an, 4'hE);
    chk("zero_seg", seg, 7'h40);
    chk_digits("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    value = 14'd1234;
    nb = 0;
    repeat (20) begin @(negedge clock); if (busy) nb++; end
    chk("busy_len", nb, 16);
    chk_digits("v1234", 7'h79, 7'h24, 7'h30, 7'h19);

    value = 14'd10000;
    repeat (20) @(negedge clock);
    chk_digits("v10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    value = 14'd56;
    repeat (6) @(negedge clock);
    value = 14'd78;
    seen56 = 0;
    repeat (32) begin @(negedge clock); if (an == 4'hE && seg == 7'h02) seen56 = 1; end
    chk("seen56", int'(seen56), 1);
    chk_digits("v78", 7'h7F, 7'h7F, 7'h78, 7'h00);

    func = 3'd5;
    repeat (3) @(negedge clock);
    chk_digits("err", 7'h06, 7'h2F, 7'h2F, 7'h7F);
    func = 3'd3;
    repeat (3) @(negedge clock);
    chk_digits("mul", 7'h2B, 7'h7F, 7'h7F, 7'h7F);
    func = 3'd0;
    repeat (2) @(negedge clock);
    chk_digits("restore", 7'h7F, 7'h7F, 7'h78, 7'h00);

    value = 14'd4321;
    repeat (5) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_an", an, 4'hF);
    chk("midrst_busy", busy, 0);
    reset = 0;
    repeat (40) @(negedge clock);
    chk_digits("v4321", 7'h19, 7'h30, 7'h24, 7'h79);

    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0: value = 14'd9999;
        1: value = 14'd10000 + 14'($urandom_range(0, 6383));
        2: value = 14'($urandom_range(0, 99));
        default: value = 14'($urandom_range(0, 16383));
      endcase
      func = $urandom_range(0, 9) < 7 ? 3'd0 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) reset = 1;
      @(negedge clock);
      reset = 0;
      repeat ($urandom_range(1, 40)) @(negedge clock);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
